// File: rtl/string_accel_avalon.sv
// Avalon-MM string accelerator: two writable string buffers (A, B), a read-only result
// buffer (R) and an engine that walks one character per clock in one of five modes.
module string_accel_avalon #(
  parameter  int MAX_WORDS = 4,
  localparam int ADDR_W    = $clog2(4 + 3 * MAX_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int CAP    = 4 * MAX_WORDS;
  localparam int IDX_W  = $clog2(CAP + 1);
  localparam int A_BASE = 4;
  localparam int B_BASE = A_BASE + MAX_WORDS;
  localparam int R_BASE = B_BASE + MAX_WORDS;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] M_CMP   = 3'd0;
  localparam logic [2:0] M_UPPER = 3'd1;
  localparam logic [2:0] M_LOWER = 3'd2;
  localparam logic [2:0] M_LEN   = 3'd3;
  localparam logic [2:0] M_FIND  = 3'd4;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       mode_q, mode_d;
  logic             irq_en_q, irq_en_d;
  logic [7:0]       len_q, len_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             err_pend_q, err_pend_d;
  logic [31:0]      result_q, result_d;
  logic [31:0]      a_q [MAX_WORDS];
  logic [31:0]      a_d [MAX_WORDS];
  logic [31:0]      b_q [MAX_WORDS];
  logic [31:0]      b_d [MAX_WORDS];
  logic [31:0]      r_q [MAX_WORDS];
  logic [31:0]      r_d [MAX_WORDS];

  logic             busy;
  logic             wr;
  logic             rd;
  int               addr;
  logic [IDX_W-1:0] limit;
  logic [7:0]       cur_a;
  logic [7:0]       cur_b;
  logic [7:0]       key;
  logic [7:0]       conv;
  logic             term;
  logic [31:0]      term_res;

  assign busy = (state_q == S_RUN);
  assign wr   = chipselect & write;
  assign rd   = chipselect & read;
  assign addr = int'(address);
  assign key  = b_q[0][31:24];
  assign irq  = done_q & irq_en_q;

  // Character 0 of a word sits in the most significant byte.
  function automatic logic [7:0] char_of(input logic [31:0] word, input logic [1:0] pos);
    return word[8 * (3 - int'(pos)) +: 8];
  endfunction

  always_comb begin
    if (len_q == 8'd0 || int'(len_q) >= CAP) limit = IDX_W'(CAP);
    else                                     limit = IDX_W'(len_q);
  end

  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int w = 0; w < MAX_WORDS; w++) begin
      if (int'(idx_q[IDX_W-1:2]) == w) begin
        cur_a = char_of(a_q[w], idx_q[1:0]);
        cur_b = char_of(b_q[w], idx_q[1:0]);
      end
    end
  end

  always_comb begin
    conv = cur_a;
    if (mode_q == M_UPPER && cur_a >= 8'h61 && cur_a <= 8'h7a)      conv = cur_a - 8'd32;
    else if (mode_q == M_LOWER && cur_a >= 8'h41 && cur_a <= 8'h5a) conv = cur_a + 8'd32;
  end

  // NOTE: next state is built here with blocking '=' so later assignments override earlier
  // ones; the register block below only copies _d into _q with non-blocking '<='.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    irq_en_d   = irq_en_q;
    len_d      = len_q;
    done_d     = done_q;
    error_d    = error_q;
    err_pend_d = err_pend_q;
    result_d   = result_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    term       = 1'b0;
    term_res   = '0;

    if (wr) begin
      if (addr == 0) begin
        if (!busy) begin
          mode_d   = writedata[3:1];
          irq_en_d = writedata[4];
          len_d    = writedata[15:8];
          if (writedata[0]) begin
            done_d   = 1'b0;
            error_d  = 1'b0;
            result_d = '0;
            if (writedata[3:1] <= M_FIND) begin
              state_d    = S_RUN;
              idx_d      = '0;
              err_pend_d = 1'b0;
              for (int w = 0; w < MAX_WORDS; w++) r_d[w] = '0;
            end else begin
              err_pend_d = 1'b1;
            end
          end
        end
      end else if (addr == 1) begin
        done_d  = 1'b0;
        error_d = 1'b0;
      end else if (!busy) begin
        for (int w = 0; w < MAX_WORDS; w++) begin
          if (addr == A_BASE + w) a_d[w] = writedata;
          if (addr == B_BASE + w) b_d[w] = writedata;
        end
      end
    end

    // Engine updates come after bus writes so a terminate beats a same-edge STATUS clear.
    if (state_q == S_RUN) begin
      if (idx_q == limit) begin
        term = 1'b1;
        if (mode_q == M_CMP)       term_res = 32'd1;
        else if (mode_q == M_FIND) term_res = 32'hFFFF_FFFF;
        else                       term_res = 32'(idx_q);
      end else begin
        case (mode_q)
          M_CMP: begin
            if (cur_a == 8'd0) begin
              term     = 1'b1;
              term_res = 32'd1;
            end else if (cur_a != cur_b) begin
              term = 1'b1;
            end
          end
          M_UPPER, M_LOWER: begin
            if (cur_a == 8'd0) begin
              term     = 1'b1;
              term_res = 32'(idx_q);
            end else begin
              for (int w = 0; w < MAX_WORDS; w++) begin
                if (int'(idx_q[IDX_W-1:2]) == w) r_d[w][8 * (3 - int'(idx_q[1:0])) +: 8] = conv;
              end
            end
          end
          M_LEN: begin
            if (cur_a == 8'd0) begin
              term     = 1'b1;
              term_res = 32'(idx_q);
            end
          end
          M_FIND: begin
            if (cur_a == key) begin
              term     = 1'b1;
              term_res = 32'(idx_q);
            end else if (cur_a == 8'd0) begin
              term     = 1'b1;
              term_res = 32'hFFFF_FFFF;
            end
          end
          default: term = 1'b1;
        endcase
      end

      if (term) begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        result_d = term_res;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (err_pend_q && state_d == S_IDLE) begin
      done_d     = 1'b1;
      error_d    = 1'b1;
      result_d   = '0;
      err_pend_d = 1'b0;
    end
  end

  // NOTE: the buffers are flip-flops, not RAM, so the asynchronous reset clears them too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mode_q     <= '0;
      irq_en_q   <= 1'b0;
      len_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_pend_q <= 1'b0;
      result_q   <= '0;
      a_q        <= '{default: '0};
      b_q        <= '{default: '0};
      r_q        <= '{default: '0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
      len_q      <= len_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_pend_q <= err_pend_d;
      result_q   <= result_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
    end
  end

  always_comb begin
    readdata = '0;
    if (rd) begin
      if (addr == 0)      readdata = {16'h0, len_q, 3'b000, irq_en_q, mode_q, 1'b0};
      else if (addr == 1) readdata = {29'h0, error_q, busy, done_q};
      else if (addr == 2) readdata = result_q;
      for (int w = 0; w < MAX_WORDS; w++) begin
        if (addr == A_BASE + w) readdata = a_q[w];
        if (addr == B_BASE + w) readdata = b_q[w];
        if (addr == R_BASE + w) readdata = r_q[w];
      end
    end
  end

endmodule

// File: tb/tb_string_accel_avalon.sv
// Directed bench for string_accel_avalon: a string-level model predicts RESULT, R and the
// done latency; STATUS and irq are compared against it every cycle of each operation.
module tb_string_accel_avalon;

  localparam int MW     = 4;
  localparam int CAP    = 4 * MW;
  localparam int ADDR_W = $clog2(4 + 3 * MW);
  localparam int A_BASE = 4;
  localparam int B_BASE = A_BASE + MW;
  localparam int R_BASE = B_BASE + MW;

  logic              clk = 1'b0;
  logic              reset;
  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [31:0]       writedata;
  logic              read;
  logic [31:0]       readdata;
  logic              irq;

  string_accel_avalon #(.MAX_WORDS(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .read       (read),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // String-level model state
  logic [7:0]  a_m [CAP];
  logic [7:0]  b_m [CAP];
  logic [7:0]  r_m [CAP];
  logic [31:0] m_res;
  int          m_lat;

  // Expected timing of the operation in flight
  int go_edge        = 0;
  int cur_lat        = 0;
  bit cur_run        = 1'b0;
  bit cur_err        = 1'b0;
  bit irq_en_m       = 1'b0;
  bit status_cleared = 1'b0;
  bit op_started     = 1'b0;
  bit mon_en         = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_done(input int k);
    return op_started && !status_cleared && (k >= cur_lat);
  endfunction

  function automatic logic [31:0] exp_status(input int k);
    logic d;
    d = exp_done(k);
    return {29'd0, cur_err && d, cur_run && (k < cur_lat), d};
  endfunction

  always @(negedge clk) begin
    if (mon_en) check("irq", {31'd0, irq}, {31'd0, irq_en_m && exp_done(cyc - go_edge)});
  end

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7a) ? c - 8'd32 : c;
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5a) ? c + 8'd32 : c;
  endfunction

  function automatic bit stops(input int mode, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] key);
    case (mode)
      0:       return (a == 8'd0) || (a != b);
      4:       return (a == key) || (a == 8'd0);
      default: return (a == 8'd0);
    endcase
  endfunction

  // Find the first stopping character within the limit, then derive RESULT and R from it.
  task automatic model_run(input int mode, input int len);
    int lim;
    int n;
    logic [7:0] key;
    lim = (len == 0 || len > CAP) ? CAP : len;
    key = b_m[0];
    n   = lim;
    for (int i = 0; i < lim; i++) begin
      if (stops(mode, a_m[i], b_m[i], key)) begin
        n = i;
        break;
      end
    end
    for (int i = 0; i < CAP; i++) r_m[i] = 8'd0;
    if (mode == 1 || mode == 2)
      for (int i = 0; i < n; i++) r_m[i] = (mode == 1) ? to_upper(a_m[i]) : to_lower(a_m[i]);
    if (n == lim)      m_res = (mode == 0) ? 32'd1 : (mode == 4) ? 32'hFFFF_FFFF : 32'(lim);
    else if (mode == 0) m_res = (a_m[n] == 8'd0) ? 32'd1 : 32'd0;
    else if (mode == 4) m_res = (a_m[n] == key) ? 32'(n) : 32'hFFFF_FFFF;
    else                m_res = 32'(n);
    m_lat = n + 1;
  endtask

  task automatic bus_write(input int addr, input logic [31:0] data);
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    read       = 1'b0;
    address    = ADDR_W'(addr);
    writedata  = data;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input int addr, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b0;
    address    = ADDR_W'(addr);
    #1;
    d = readdata;
  endtask

  task automatic check_read(input string name, input int addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(name, d, exp);
  endtask

  task automatic load_str(input int base, input string s, input bit is_b);
    logic [31:0] word;
    logic [7:0]  c;
    for (int w = 0; w < MW; w++) begin
      word = '0;
      for (int k = 0; k < 4; k++) begin
        c = (4 * w + k < s.len()) ? s[4 * w + k] : 8'h00;
        word[8 * (3 - k) +: 8] = c;
        if (is_b) b_m[4 * w + k] = c;
        else      a_m[4 * w + k] = c;
      end
      bus_write(base + w, word);
    end
  endtask

  task automatic start_op(input int mode, input int len, input bit irq_en);
    bus_write(0, {16'h0, 8'(len), 3'b000, irq_en, 3'(mode), 1'b1});
    go_edge        = cyc;
    cur_run        = (mode < 5);
    cur_err        = (mode >= 5);
    cur_lat        = (mode < 5) ? m_lat : 1;
    irq_en_m       = irq_en;
    status_cleared = 1'b0;
    op_started     = 1'b1;
  endtask

  // Samples STATUS once per cycle after each edge from the go edge until edge go+upto.
  task automatic poll_status(input string name, input int upto);
    logic [31:0] d;
    int k;
    while (cyc - go_edge < upto) begin
      bus_read(1, d);
      k = cyc - go_edge;
      check(name, d, exp_status(k));
    end
  endtask

  task automatic clear_status();
    bus_write(1, 32'h0);
    status_cleared = 1'b1;
  endtask

  task automatic check_r_words(input string name);
    for (int w = 0; w < MW; w++)
      check_read(name, R_BASE + w, {r_m[4 * w], r_m[4 * w + 1], r_m[4 * w + 2], r_m[4 * w + 3]});
  endtask

  task automatic run_op(input string name, input int mode, input int len,
                        input logic [31:0] lit_res, input int lit_lat);
    model_run(mode, len);
    check({name, "_model_lat"}, 32'(m_lat), 32'(lit_lat));
    check({name, "_model_res"}, m_res, lit_res);
    start_op(mode, len, 1'b0);
    poll_status({name, "_status"}, cur_lat);
    check_read({name, "_result"}, 2, m_res);
    check_read({name, "_result_lit"}, 2, lit_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = '0;
    writedata  = '0;
    for (int i = 0; i < CAP; i++) begin
      a_m[i] = 8'd0;
      b_m[i] = 8'd0;
      r_m[i] = 8'd0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check_read("rst_ctrl", 0, 32'h0);
    check_read("rst_status", 1, 32'h0);
    check_read("rst_result", 2, 32'h0);
    check_read("rst_addr3", 3, 32'h0);
    check_read("rst_a0", A_BASE, 32'h0);
    check_read("rst_b0", B_BASE, 32'h0);
    check_read("rst_r0", R_BASE, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    mon_en = 1'b1;

    // Compare: mismatch at index 3, then full match ending on the NUL at index 4
    load_str(A_BASE, "abcd", 1'b0);
    load_str(B_BASE, "abca", 1'b1);
    run_op("cmp_ne", 0, 0, 32'd0, 4);
    load_str(B_BASE, "abcd", 1'b1);
    run_op("cmp_eq", 0, 0, 32'd1, 5);

    // Case conversion, unlimited and with len=2
    load_str(A_BASE, "hello world!", 1'b0);
    run_op("upper", 1, 0, 32'd12, 13);
    check_r_words("upper_r");
    check_read("upper_r0_lit", R_BASE + 0, 32'h48454C4C);
    check_read("upper_r1_lit", R_BASE + 1, 32'h4F20574F);
    check_read("upper_r2_lit", R_BASE + 2, 32'h524C4421);
    check_read("upper_r3_lit", R_BASE + 3, 32'h0);

    load_str(A_BASE, "AbCd", 1'b0);
    run_op("lower", 2, 2, 32'd2, 3);
    check_r_words("lower_r");
    check_read("lower_r0_lit", R_BASE, 32'h61620000);

    // Find: hit, then miss ending on the NUL
    load_str(A_BASE, "abcdefgh", 1'b0);
    load_str(B_BASE, "f", 1'b1);
    run_op("find", 4, 0, 32'd5, 6);
    @(negedge clk);
    chipselect = 1'b1;
    read       = 1'b0;
    address    = ADDR_W'(2);
    #1;
    check("no_read_zero", readdata, 32'h0);
    load_str(B_BASE, "z", 1'b1);
    run_op("find_miss", 4, 0, 32'hFFFF_FFFF, 9);

    // Length at full capacity with irq enabled and an ignored write to A mid-run
    load_str(A_BASE, "ABCDEFGHIJKLMNOP", 1'b0);
    model_run(3, 0);
    check("len_model_lat", 32'(m_lat), 32'd17);
    start_op(3, 0, 1'b1);
    poll_status("len_status", 2);
    bus_write(A_BASE, 32'h58585858);
    poll_status("len_status", cur_lat);
    check_read("len_result", 2, 32'd16);
    check_read("len_a0_kept", A_BASE, 32'h41424344);
    check("len_irq_high", {31'd0, irq}, 32'd1);
    clear_status();
    @(negedge clk);
    #1;
    check("len_irq_low", {31'd0, irq}, 32'd0);
    check_read("len_status_clr", 1, 32'h0);

    // Illegal mode: error and done one cycle after the go edge, busy never set
    start_op(6, 0, 1'b0);
    poll_status("err_status", 2);
    check_read("err_status_lit", 1, 32'h5);
    check_read("err_result", 2, 32'h0);
    clear_status();
    check_read("err_status_clr", 1, 32'h0);

    // Reset while a length run sits at index 3
    model_run(3, 0);
    start_op(3, 0, 1'b0);
    while (cyc - go_edge < 3) @(negedge clk);
    mon_en = 1'b0;
    #1;
    reset      = 1'b1;
    chipselect = 1'b1;
    read       = 1'b1;
    address    = ADDR_W'(1);
    #1;
    check("midrst_status", readdata, 32'h0);
    op_started = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_read("midrst_ctrl", 0, 32'h0);
    check_read("midrst_result", 2, 32'h0);
    check_read("midrst_a0", A_BASE, 32'h0);
    check_read("midrst_b0", B_BASE, 32'h0);
    check_read("midrst_r0", R_BASE, 32'h0);
    repeat (20) @(negedge clk);
    check_read("midrst_status_late", 1, 32'h0);
    check("midrst_irq", {31'd0, irq}, 32'd0);

    chipselect = 1'b0;
    read       = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
